branch_resolve_queue: RTL
=========================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight branch entries; power of two, at least 2.
REQ-002 Parameter PTR_W, default 2, equal to log2(DEPTH).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 allocD  input  1  branch in D, with prediction attached, requests an entry.
REQ-006 stallD  input  1  D stalled; allocD is ignored while this is high.
REQ-007 pcD / pred_takeD / pred_targetD  input  32/1/32  branch PC, predicted direction and predicted target.
REQ-008 resolveM  input  1  oldest branch has reached M and its outcome is known.
REQ-009 actual_takeM / actual_targetM  input  1/32  resolved direction and resolved target.
REQ-010 full / empty  output  1/1  queue occupancy flags (combinational).
REQ-011 stall_o  output  1  back-pressure to D: full and no resolveM this cycle.
REQ-012 upd_valid / upd_take / upd_correct / upd_pc  output  1/1/1/32  registered predictor update, one cycle after resolveM.
REQ-013 flush_o  output  1  flush D/E/M pipeline registers.
REQ-014 redirect_valid / redirect_pc  output  1/32  fetch redirect.
REQ-015 err_o  output  1  sticky protocol error flag.
REQ-016 resolved_cnt / mispred_cnt  output  32/32  statistics counters.

Function
REQ-017 Entry format: {pc, pred_take, pred_target}; storage is circular, with head/tail pointers PTR_W wide and a count PTR_W+1 wide.
REQ-018 Allocation: an entry is written at tail, then tail and count increment, when allocD is high, stallD is low, stall_o is low, and state is IDLE.
REQ-019 Resolution: in IDLE with resolveM high and the queue not empty, the head entry is popped and compared against the actual outcome.
REQ-020 Correct when pred_take equals actual_takeM and, if taken, pred_target equals actual_targetM.
REQ-021 Update outputs are valid the cycle after resolution:
  - upd_valid=1, upd_take=actual_takeM, upd_correct as in REQ-020, upd_pc=head pc.
  - upd_valid is a one-cycle pulse.
REQ-022 Simultaneous allocate and resolve in one cycle: both take effect; count is unchanged; allocation is accepted even when full.
REQ-023 Pointers wrap modulo DEPTH; count never exceeds DEPTH and never goes below 0.
REQ-024 FSM states IDLE, FLUSH, RECOVER.
  - IDLE to FLUSH on a mispredicting resolution.
  - FLUSH to RECOVER unconditionally.
  - RECOVER to IDLE unconditionally.
REQ-025 FLUSH, one cycle:
  - flush_o=1 and redirect_valid=1.
  - redirect_pc = actual target if taken, else resolved pc+8 (delay slot).
  - All entries are discarded: head=tail, count=0.
REQ-026 RECOVER, one cycle: stall_o=1; no allocation and no resolution accepted.
REQ-027 In FLUSH and RECOVER, allocD and resolveM are ignored.
REQ-028 A correct resolution causes no flush and no redirect; the pipeline is not disturbed.
REQ-029 err_o is set on resolveM while empty (in IDLE); the queue is not modified in that case. err_o clears only on rst.
REQ-030 redirect_pc and upd_pc hold their last value when not valid.

Reset
REQ-031 On rst:
  - head=tail=count=0, state=IDLE.
  - All outputs 0, except empty=1.
  - err_o=0; counters 0.
REQ-032 rst overrides every in-progress FLUSH or RECOVER; entry storage contents need not be cleared.

Configuration
REQ-033 Macro BRQ_STATS_EN.
  - Defined: resolved_cnt increments on every accepted resolution; mispred_cnt increments on every incorrect one. Both wrap at 2^32.
  - Undefined: both outputs are constant 0 and no counter flops exist.

Verification
REQ-034 Alloc pc 0x100, pred_take=1, target 0x200; resolve actual_take=1, target 0x200 -> next cycle upd_valid=1, upd_correct=1, flush_o=0, empty=1.
REQ-035 Alloc pc 0x100, pred_take=0; resolve actual_take=1, target 0x300 -> flush_o=1, redirect_pc=0x300, then one RECOVER cycle with stall_o=1, then IDLE with empty=1.
REQ-036 Alloc pc 0x104, pred_take=1; resolve actual_take=0 -> redirect_pc=0x10C.
REQ-037 4 allocs with DEPTH=4 -> full=1 and stall_o=1; 5th alloc with a simultaneous resolve -> accepted, count stays 4; resolved pcs come out in FIFO order across the pointer wrap.
REQ-038 resolveM while empty -> err_o=1 and remains 1 until rst; the queue remains empty.
REQ-039 rst asserted during FLUSH -> next cycle flush_o=0, state IDLE, empty=1; with BRQ_STATS_EN, a 3-resolve/1-mispredict sequence gives resolved_cnt=3, mispred_cnt=1.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// Branch resolution queue: tracks predicted branches from D until M resolves them,
// producing predictor updates and a flush/redirect on mispredicts. Optional stats via BRQ_STATS_EN.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              allocD,
    input  logic              stallD,
    input  logic [31:0]       pcD,
    input  logic              pred_takeD,
    input  logic [31:0]       pred_targetD,
    input  logic              resolveM,
    input  logic              actual_takeM,
    input  logic [31:0]       actual_targetM,
    output logic              full,
    output logic              empty,
    output logic              stall_o,
    output logic              upd_valid,
    output logic              upd_take,
    output logic              upd_correct,
    output logic [31:0]       upd_pc,
    output logic              flush_o,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              err_o,
    output logic [31:0]       resolved_cnt,
    output logic [31:0]       mispred_cnt
);

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        predTake;
        logic [31:0] predTarget;
    } entry_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    state_t           state, stateNext;

    entry_t headEntry;
    logic   isIdle, doAlloc, doResolve, predCorrect, mispredict;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        headEntry      = mem[head];
        isIdle         = (state == IDLE);
        full           = (count == CNT_FULL);
        empty          = (count == '0);
        stall_o        = (state == RECOVER) || (full && !resolveM);
        flush_o        = (state == FLUSH);
        redirect_valid = (state == FLUSH);
        doAlloc        = isIdle && allocD && !stallD && !stall_o;
        doResolve      = isIdle && resolveM && !empty;
        predCorrect    = (headEntry.predTake == actual_takeM) &&
                         (!actual_takeM || (headEntry.predTarget == actual_targetM));
        mispredict     = doResolve && !predCorrect;

        stateNext = state;
        case (state)
            IDLE:    if (mispredict) stateNext = FLUSH;
            FLUSH:   stateNext = RECOVER;
            RECOVER: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= stateNext;
            if (state == FLUSH) begin
                // Discard everything still in flight, including anything pushed alongside the mispredict.
                head  <= tail;
                count <= '0;
            end else begin
                if (doAlloc)   tail <= tail + PTR_ONE;
                if (doResolve) head <= head + PTR_ONE;
                case ({doAlloc, doResolve})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: entry storage is deliberately not reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (doAlloc) mem[tail] <= '{pc: pcD, predTake: pred_takeD, predTarget: pred_targetD};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid   <= 1'b0;
            upd_take    <= 1'b0;
            upd_correct <= 1'b0;
            upd_pc      <= '0;
            redirect_pc <= '0;
            err_o       <= 1'b0;
        end else begin
            upd_valid <= doResolve;
            if (doResolve) begin
                upd_take    <= actual_takeM;
                upd_correct <= predCorrect;
                upd_pc      <= headEntry.pc;
            end
            // Not-taken resolution falls through past the delay slot.
            if (mispredict)
                redirect_pc <= actual_takeM ? actual_targetM : headEntry.pc + 32'd8;
            if (isIdle && resolveM && empty)
                err_o <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_cnt <= '0;
            mispred_cnt  <= '0;
        end else begin
            if (doResolve)  resolved_cnt <= resolved_cnt + 32'd1;
            if (mispredict) mispred_cnt  <= mispred_cnt + 32'd1;
        end
    end
`else
    assign resolved_cnt = '0;
    assign mispred_cnt  = '0;
`endif

endmodule
